// File: rtl/result_forward_pipe_pkg.sv
// Shared types for the result forwarding pipe (DEC->EXE->MEM->WRB).
// Stage record, load-FSM states and datapath widths.
package result_forward_pipe_pkg;

  localparam int XLEN      = 32;
  localparam int NREG_BITS = 5;

  typedef enum logic {
    LD_IDLE,
    LD_WAIT
  } ld_state_e;

  typedef struct packed {
    logic                 valid;
    logic [NREG_BITS-1:0] rd;
    logic                 wenb;
    logic                 load;
    logic                 csr;
    logic [XLEN-1:0]      result;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // x0 is never written or forwarded
  function automatic logic fwd_wenb(
    input logic                 v,
    input logic                 w,
    input logic [NREG_BITS-1:0] rd
  );
    return v & w & (rd != '0);
  endfunction

endpackage

// File: rtl/result_forward_pipe_if.sv
// Data-memory load handshake between the MEM stage and data memory.
// master = core side, slave = memory side.
interface result_forward_pipe_if;
  import result_forward_pipe_pkg::*;

  logic            dmem_req;
  logic [XLEN-1:0] dmem_addr;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_addr,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_addr,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/result_forward_pipe_load_handshake_fsm.sv
// Load request sequencer for the MEM stage.
// Raises dmem_req for a MEM load and freezes the pipe until ack.
module load_handshake_fsm
  import result_forward_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic            mem_load,
  input  logic [XLEN-1:0] mem_addr,
  input  logic            dmem_ack,
  output logic            dmem_req,
  output logic [XLEN-1:0] dmem_addr,
  output logic            pipe_hold
);

  ld_state_e state_q;
  ld_state_e state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        if (mem_valid & mem_load) begin
          dmem_req = 1'b1;
          if (!dmem_ack) state_d = LD_WAIT;
        end
      end
      LD_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  assign dmem_addr = dmem_req ? mem_addr : '0;
  assign pipe_hold = mem_valid & mem_load & ~dmem_ack;

endmodule

// File: rtl/result_forward_pipe.sv
// Operand-forwarding producer: EXE/MEM/WRB registers and RF write port.
// Optional RESULT_PIPE_PERF_EN adds saturating perf counters.
module result_forward_pipe
  import result_forward_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  input  logic                 dec_stall,
  input  logic [NREG_BITS-1:0] dec_rd,
  input  logic                 dec_rd_wenb,
  input  logic                 dec_load,
  input  logic                 dec_csr,
  input  logic                 exe_flush,
  input  logic [XLEN-1:0]      exe_alu_result,
  input  logic [XLEN-1:0]      exe_csr_rdata,
  result_forward_pipe_if.master dmem,
  output logic [NREG_BITS-1:0] exe_rd,
  output logic [NREG_BITS-1:0] mem_rd,
  output logic [NREG_BITS-1:0] wrb_rd,
  output logic                 exe_rd_wenb,
  output logic                 mem_rd_wenb,
  output logic                 wrb_rd_wenb,
  output logic [XLEN-1:0]      exe_result,
  output logic [XLEN-1:0]      mem_result,
  output logic [XLEN-1:0]      wrb_result,
  output logic                 exe_load,
  output logic                 exe_csr,
  output logic                 pipe_hold,
  output logic                 rf_wenb,
  output logic [NREG_BITS-1:0] rf_waddr,
  output logic [XLEN-1:0]      rf_wdata
`ifdef RESULT_PIPE_PERF_EN
  ,
  output logic [31:0]          perf_bubbles,
  output logic [31:0]          perf_load_wait,
  output logic [31:0]          perf_retired
`endif
);

  stage_t exe_q, mem_q, wrb_q;
  stage_t dec_d, mem_d, wrb_d;
  logic   pend_q;
  logic   exe_bubble;

  assign exe_bubble = exe_flush | pend_q | dec_stall | ~dec_valid;

  always_comb begin
    dec_d        = STAGE_BUBBLE;
    dec_d.valid  = 1'b1;
    dec_d.rd     = dec_rd;
    dec_d.wenb   = dec_rd_wenb;
    dec_d.load   = dec_load;
    dec_d.csr    = dec_csr;
    mem_d        = exe_q;
    mem_d.result = exe_result;
    wrb_d        = mem_q;
    wrb_d.result = mem_result;
  end

  // a held MEM load leaves WRB empty so rd is written exactly once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_q  <= STAGE_BUBBLE;
      mem_q  <= STAGE_BUBBLE;
      wrb_q  <= STAGE_BUBBLE;
      pend_q <= 1'b0;
    end else if (!pipe_hold) begin
      exe_q  <= exe_bubble ? STAGE_BUBBLE : dec_d;
      mem_q  <= mem_d;
      wrb_q  <= wrb_d;
      pend_q <= 1'b0;
    end else begin
      wrb_q  <= STAGE_BUBBLE;
      if (exe_flush) pend_q <= 1'b1;
    end
  end

  load_handshake_fsm u_ld_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_valid (mem_q.valid),
    .mem_load  (mem_q.load),
    .mem_addr  (mem_q.result),
    .dmem_ack  (dmem.dmem_ack),
    .dmem_req  (dmem.dmem_req),
    .dmem_addr (dmem.dmem_addr),
    .pipe_hold (pipe_hold)
  );

  assign exe_rd      = exe_q.rd;
  assign exe_load    = exe_q.load;
  assign exe_csr     = exe_q.csr;
  assign exe_rd_wenb = fwd_wenb(exe_q.valid, exe_q.wenb, exe_q.rd);
  assign exe_result  = exe_q.csr ? exe_csr_rdata : exe_alu_result;

  assign mem_rd      = mem_q.rd;
  assign mem_rd_wenb = fwd_wenb(mem_q.valid, mem_q.wenb, mem_q.rd)
                     & (~mem_q.load | dmem.dmem_ack);
  assign mem_result  = mem_q.load ? dmem.dmem_rdata : mem_q.result;

  assign wrb_rd      = wrb_q.rd;
  assign wrb_rd_wenb = fwd_wenb(wrb_q.valid, wrb_q.wenb, wrb_q.rd);
  assign wrb_result  = wrb_q.result;

  assign rf_wenb  = wrb_rd_wenb;
  assign rf_waddr = wrb_rd;
  assign rf_wdata = wrb_result;

  logic unused_fields;
  assign unused_fields = ^{exe_q.result, mem_q.csr, wrb_q.load, wrb_q.csr};

`ifdef RESULT_PIPE_PERF_EN
  function automatic logic [31:0] sat_inc(
    input logic [31:0] c,
    input logic        en
  );
    return (en && c != '1) ? c + 32'd1 : c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubbles   <= '0;
      perf_load_wait <= '0;
      perf_retired   <= '0;
    end else begin
      perf_bubbles   <= sat_inc(perf_bubbles, ~pipe_hold & exe_bubble);
      perf_load_wait <= sat_inc(perf_load_wait, pipe_hold);
      perf_retired   <= sat_inc(perf_retired, rf_wenb);
    end
  end
`endif

endmodule

// File: tb/tb_result_forward_pipe.sv
// Directed + randomized bench for result_forward_pipe.
// Random phase is checked against a rule-level pipeline model.
module tb_result_forward_pipe;
  import result_forward_pipe_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 dec_valid = 1'b0, dec_stall = 1'b0;
  logic [NREG_BITS-1:0] dec_rd = '0;
  logic                 dec_rd_wenb = 1'b0, dec_load = 1'b0, dec_csr = 1'b0;
  logic                 exe_flush = 1'b0;
  logic [XLEN-1:0]      exe_alu_result = '0, exe_csr_rdata = '0;
  logic                 ack = 1'b0;
  logic [XLEN-1:0]      rdata = '0;
  logic [NREG_BITS-1:0] exe_rd, mem_rd, wrb_rd, rf_waddr;
  logic                 exe_rd_wenb, mem_rd_wenb, wrb_rd_wenb;
  logic [XLEN-1:0]      exe_result, mem_result, wrb_result, rf_wdata;
  logic                 exe_load, exe_csr, pipe_hold, rf_wenb;
  logic                 req;
  logic [XLEN-1:0]      addr;
`ifdef RESULT_PIPE_PERF_EN
  logic [31:0] perf_bubbles, perf_load_wait, perf_retired;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_forward_pipe_if dmem ();
  assign dmem.dmem_ack   = ack;
  assign dmem.dmem_rdata = rdata;
  assign req  = dmem.dmem_req;
  assign addr = dmem.dmem_addr;

  result_forward_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_stall(dec_stall), .dec_rd(dec_rd),
    .dec_rd_wenb(dec_rd_wenb), .dec_load(dec_load), .dec_csr(dec_csr),
    .exe_flush(exe_flush), .exe_alu_result(exe_alu_result),
    .exe_csr_rdata(exe_csr_rdata), .dmem(dmem.master),
    .exe_rd(exe_rd), .mem_rd(mem_rd), .wrb_rd(wrb_rd),
    .exe_rd_wenb(exe_rd_wenb), .mem_rd_wenb(mem_rd_wenb),
    .wrb_rd_wenb(wrb_rd_wenb), .exe_result(exe_result),
    .mem_result(mem_result), .wrb_result(wrb_result),
    .exe_load(exe_load), .exe_csr(exe_csr), .pipe_hold(pipe_hold),
    .rf_wenb(rf_wenb), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef RESULT_PIPE_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_load_wait(perf_load_wait),
    .perf_retired(perf_retired)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic dec(input logic v, input logic [4:0] rd,
                     input logic we, input logic ld);
    dec_valid = v; dec_rd = rd; dec_rd_wenb = we;
    dec_load = ld; dec_csr = 1'b0; dec_stall = 1'b0;
  endtask

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       csr;
    logic [31:0] val;
  } rec_t;

  rec_t        m_exe, m_mem, dec_r;
  logic        m_pend, w_v;
  logic [4:0]  w_rd;
  logic [31:0] w_val;
  logic        e_req, e_hold, e_exe_we, e_mem_we;
  logic [31:0] e_exe_res;

  initial begin
    // reset values
    #3;
    chk("rst_exe_wenb", {31'b0, exe_rd_wenb}, 0);
    chk("rst_exe_rd", {27'b0, exe_rd}, 0);
    chk("rst_mem_rd", {27'b0, mem_rd}, 0);
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_hold", {31'b0, pipe_hold}, 0);
    chk("rst_rf_wenb", {31'b0, rf_wenb}, 0);
    chk("rst_wrb_result", wrb_result, 0);
    #9 rst_n = 1'b1;
    tick();

    // 1: back-to-back ALU ops
    dec(1, 5, 1, 0);
    tick();
    dec(1, 6, 1, 0); exe_alu_result = 32'h11;
    settle();
    chk("t1_exe_rd5", {27'b0, exe_rd}, 5);
    chk("t1_exe_res", exe_result, 32'h11);
    tick();
    dec(0, 0, 0, 0); exe_alu_result = 32'h22;
    settle();
    chk("t1_mem_rd5", {27'b0, mem_rd}, 5);
    chk("t1_exe_rd6", {27'b0, exe_rd}, 6);
    chk("t1_mem_res", mem_result, 32'h11);
    tick();
    settle();
    chk("t1_rf_we", {31'b0, rf_wenb}, 1);
    chk("t1_rf_addr", {27'b0, rf_waddr}, 5);
    chk("t1_rf_data", rf_wdata, 32'h11);
    tick();
    settle();
    chk("t1_rf_addr6", {27'b0, rf_waddr}, 6);
    chk("t1_rf_data6", rf_wdata, 32'h22);
    tick();

    // 2: stall inserts a bubble
    dec(1, 9, 1, 0); dec_stall = 1'b1;
    tick();
    settle();
    chk("t2_bub_wenb", {31'b0, exe_rd_wenb}, 0);
    chk("t2_bub_rd", {27'b0, exe_rd}, 0);
    dec_stall = 1'b0;
    tick();
    dec(0, 0, 0, 0);
    settle();
    chk("t2_rd9", {27'b0, exe_rd}, 9);
    chk("t2_wenb9", {31'b0, exe_rd_wenb}, 1);
    repeat (3) tick();

    // 3: load rd=7 with three wait cycles
    dec(1, 7, 1, 1);
    tick();
    dec(0, 0, 0, 0); exe_alu_result = 32'h100;
    settle();
    chk("t3_exe_load", {31'b0, exe_load}, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_hold", {31'b0, pipe_hold}, 1);
      chk("t3_req", {31'b0, req}, 1);
      chk("t3_addr", addr, 32'h100);
      chk("t3_mem_wenb", {31'b0, mem_rd_wenb}, 0);
      chk("t3_no_rf", {31'b0, rf_wenb}, 0);
      tick();
    end
    ack = 1'b1; rdata = 32'hDEADBEEF;
    settle();
    chk("t3_hold_ack", {31'b0, pipe_hold}, 0);
    chk("t3_mem_wenb_ack", {31'b0, mem_rd_wenb}, 1);
    tick();
    ack = 1'b0;
    settle();
    chk("t3_req_done", {31'b0, req}, 0);
    chk("t3_rf_addr", {27'b0, rf_waddr}, 7);
    chk("t3_rf_data", rf_wdata, 32'hDEADBEEF);
    chk("t3_rf_we", {31'b0, rf_wenb}, 1);
    tick();

    // 4: zero-wait load
    dec(1, 8, 1, 1);
    tick();
    dec(0, 0, 0, 0); exe_alu_result = 32'h200;
    tick();
    ack = 1'b1; rdata = 32'hCAFEF00D;
    settle();
    chk("t4_req", {31'b0, req}, 1);
    chk("t4_hold", {31'b0, pipe_hold}, 0);
    chk("t4_mem_res", mem_result, 32'hCAFEF00D);
    tick();
    ack = 1'b0;
    settle();
    chk("t4_req_off", {31'b0, req}, 0);
    chk("t4_rf_data", rf_wdata, 32'hCAFEF00D);
    tick();

    // 5: flush during load wait
    dec(1, 10, 1, 1);
    tick();
    dec(1, 11, 1, 0); exe_alu_result = 32'h300;
    tick();
    dec(1, 12, 1, 0); exe_alu_result = 32'h33; exe_flush = 1'b1;
    settle();
    chk("t5_hold", {31'b0, pipe_hold}, 1);
    tick();
    exe_flush = 1'b0;
    settle();
    chk("t5_exe_held", {27'b0, exe_rd}, 11);
    tick();
    ack = 1'b1; rdata = 32'h5555AAAA;
    settle();
    chk("t5_exe_held2", {27'b0, exe_rd}, 11);
    tick();
    ack = 1'b0;
    settle();
    chk("t5_bubble_rd", {27'b0, exe_rd}, 0);
    chk("t5_bubble_we", {31'b0, exe_rd_wenb}, 0);
    chk("t5_mem_rd", {27'b0, mem_rd}, 11);
    chk("t5_rf_data", rf_wdata, 32'h5555AAAA);
    tick();
    dec(0, 0, 0, 0);
    settle();
    chk("t5_next_rd", {27'b0, exe_rd}, 12);
    chk("t5_rf11", rf_wdata, 32'h33);
    repeat (3) tick();

    // 6a: rd=0 never enables a write
    dec(1, 0, 1, 0);
    tick();
    dec(0, 0, 0, 0);
    settle();
    chk("t6_exe_we0", {31'b0, exe_rd_wenb}, 0);
    tick();
    settle();
    chk("t6_mem_we0", {31'b0, mem_rd_wenb}, 0);
    tick();
    settle();
    chk("t6_rf_we0", {31'b0, rf_wenb}, 0);
    tick();

    // 6b: async reset while waiting on a load
    dec(1, 13, 1, 1);
    tick();
    dec(0, 0, 0, 0); exe_alu_result = 32'h400;
    tick();
    tick();
    settle();
    chk("t6_wait_req", {31'b0, req}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", {31'b0, req}, 0);
    chk("t6_rst_hold", {31'b0, pipe_hold}, 0);
    chk("t6_rst_mem_rd", {27'b0, mem_rd}, 0);
    chk("t6_rst_exe_load", {31'b0, exe_load}, 0);
    chk("t6_rst_rf_we", {31'b0, rf_wenb}, 0);
    #1 rst_n = 1'b1;
    tick();

    // randomized phase against the model
    m_exe = '0; m_mem = '0; m_pend = 1'b0;
    w_v = 1'b0; w_rd = '0; w_val = '0;
    for (int c = 0; c < 400; c++) begin
      dec_valid   = ($urandom_range(3) != 0);
      dec_stall   = ($urandom_range(4) == 0);
      dec_rd      = 5'($urandom_range(31));
      if ($urandom_range(7) == 0) dec_rd = '0;
      dec_rd_wenb = ($urandom_range(4) != 0);
      dec_load    = ($urandom_range(2) == 0);
      dec_csr     = !dec_load && ($urandom_range(5) == 0);
      exe_flush   = ($urandom_range(9) == 0);
      exe_alu_result = $urandom;
      exe_csr_rdata  = $urandom;
      ack   = ($urandom_range(2) == 0);
      rdata = $urandom;
      settle();

      e_req     = m_mem.v && m_mem.ld;
      e_hold    = e_req && !ack;
      e_exe_we  = m_exe.v && m_exe.we && (m_exe.rd != 0);
      e_mem_we  = m_mem.v && m_mem.we && (m_mem.rd != 0)
                  && (!m_mem.ld || ack);
      e_exe_res = m_exe.csr ? exe_csr_rdata : exe_alu_result;

      chk("rnd_hold", {31'b0, pipe_hold}, {31'b0, e_hold});
      chk("rnd_req", {31'b0, req}, {31'b0, e_req});
      chk("rnd_exe_rd", {27'b0, exe_rd}, {27'b0, m_exe.rd});
      chk("rnd_exe_we", {31'b0, exe_rd_wenb}, {31'b0, e_exe_we});
      chk("rnd_exe_res", exe_result, e_exe_res);
      chk("rnd_mem_rd", {27'b0, mem_rd}, {27'b0, m_mem.rd});
      chk("rnd_mem_we", {31'b0, mem_rd_wenb}, {31'b0, e_mem_we});
      chk("rnd_rf_we", {31'b0, rf_wenb}, {31'b0, w_v});
      if (e_req) chk("rnd_addr", addr, m_mem.val);
      if (w_v) begin
        chk("rnd_rf_addr", {27'b0, rf_waddr}, {27'b0, w_rd});
        chk("rnd_rf_data", rf_wdata, w_val);
      end

      dec_r = '{v: 1'b1, rd: dec_rd, we: dec_rd_wenb, ld: dec_load,
                csr: dec_csr, val: 32'h0};
      if (!e_hold) begin
        w_v   = e_mem_we;
        w_rd  = m_mem.rd;
        w_val = m_mem.ld ? rdata : m_mem.val;
        m_mem = m_exe;
        m_mem.val = e_exe_res;
        if (exe_flush || m_pend || dec_stall || !dec_valid) m_exe = '0;
        else m_exe = dec_r;
        m_pend = 1'b0;
      end else begin
        w_v = 1'b0;
        if (exe_flush) m_pend = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_forward_pipe.md
Name: result_forward_pipe

Overview:
- Producer side of the RISC-V core's operand-forwarding interface: owns the DEC→EXE, EXE→MEM and MEM→WRB pipeline registers.
- Generates every exe_/mem_/wrb_ rd, wenb and result signal consumed by the DEC-stage bypass/stall logic.
- Accepts DEC's stall: a stalled or invalid DEC inserts a bubble into EXE.
- Sequences the load-data handshake with data memory in MEM, holding the whole pipe on wait states.
- Drives the register-file write port from WRB.

Parameters:
XLEN, 32, datapath/result width
NREG_BITS, 5, register address width

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  DEC holds a valid instruction
dec_stall  in  1  bypass/stall request; DEC must not advance
dec_rd  in  NREG_BITS  DEC destination register
dec_rd_wenb  in  1  DEC instruction writes rd
dec_load  in  1  DEC instruction is a load
dec_csr  in  1  DEC instruction is CSRRx
exe_flush  in  1  branch/trap kill of the instruction entering EXE
exe_alu_result  in  XLEN  ALU result for current EXE instruction
exe_csr_rdata  in  XLEN  CSR read data for current EXE instruction
dmem_ack  in  1  load data valid this cycle
dmem_rdata  in  XLEN  load data
exe_rd / mem_rd / wrb_rd  out  NREG_BITS  stage destination registers
exe_rd_wenb / mem_rd_wenb / wrb_rd_wenb  out  1  stage write enables
exe_result / mem_result / wrb_result  out  XLEN  stage results
exe_load, exe_csr  out  1  EXE instruction class
dmem_req  out  1  load request to data memory
dmem_addr  out  XLEN  load address
pipe_hold  out  1  freeze DEC and all stage registers
rf_wenb  out  1  register-file write enable
rf_waddr  out  NREG_BITS  register-file write address
rf_wdata  out  XLEN  register-file write data

Behaviour:
Reset:
- All stage valids, rd, wenb, load and csr fields are 0; results are 0.
- dmem_req, pipe_hold and rf_wenb are 0.
- Load FSM is IDLE; pending-flush flag is 0.

Write-enable gating:
- Every stage output wenb equals valid AND stored wenb AND (rd != 0).
- x0 is never written or forwarded.

EXE register, evaluated at each edge with this priority:
- pipe_hold: hold all fields.
- Else exe_flush, pending-flush flag, dec_stall or !dec_valid: insert bubble (valid=0, wenb=0, load=0, csr=0, rd=0).
- Else capture the dec_* fields.
- exe_result is combinational: exe_csr ? exe_csr_rdata : exe_alu_result.

MEM register:
- If !pipe_hold, capture EXE valid/rd/wenb/load, with mem_alu_q = exe_result.

MEM outputs:
- mem_result = mem_load ? dmem_rdata : mem_alu_q.
- For a load, mem_rd_wenb is additionally gated by dmem_ack.

Load FSM, states IDLE and WAIT:
- IDLE: mem_valid & mem_load drives dmem_req=1 and dmem_addr=mem_alu_q.
  - With dmem_ack in the same cycle (zero-wait), stay IDLE.
  - Without ack, go to WAIT.
- WAIT: dmem_req stays 1 until dmem_ack, then return to IDLE.
- dmem_ack when dmem_req=0 is ignored.
- pipe_hold = mem_valid & mem_load & !dmem_ack (combinational).

WRB register:
- If !pipe_hold, capture mem valid/rd/wenb and mem_result.
- If pipe_hold, WRB becomes a bubble, so the register file is not written twice.
- rf_wenb = wrb_rd_wenb, rf_waddr = wrb_rd, rf_wdata = wrb_result.

Flush during hold:
- exe_flush while pipe_hold sets the pending-flush flag.
- The flag causes a bubble at the first non-hold edge, then clears.

Latency and ordering:
- One cycle per stage; the instruction order is never changed.

Reset mid-operation:
- Reset asserted during WAIT returns to IDLE with dmem_req=0 immediately (asynchronous).

Optional Feature:
RESULT_PIPE_PERF_EN
- Defined: adds 32-bit saturating counters and outputs:
  - perf_bubbles (EXE bubble insertions)
  - perf_load_wait (cycles with pipe_hold=1)
  - perf_retired (rf_wenb pulses)
- Counters reset to 0.
- Not defined: the counters and their ports are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - XLEN and NREG_BITS constants
  - load-FSM state enum (IDLE, WAIT)
  - stage-record typedef {valid, rd, wenb, load, csr, result}
- One sub-module is natural: load_handshake_fsm, which produces dmem_req, dmem_addr and pipe_hold.

Test Plan:
1. Back-to-back ALU ops, DEC rd=5 then rd=6, results 0x11 and 0x22 → exe_rd=5 in cycle 1, mem_rd=5/exe_rd=6 in cycle 2, rf write x5=0x11 in cycle 3.
2. dec_stall=1 with a valid DEC → next cycle exe_rd_wenb=0, exe_rd=0; the held instruction enters EXE after stall drops.
3. Load rd=7 with dmem_ack delayed 3 cycles → pipe_hold=1 and dmem_req=1 for 3 cycles, mem_rd_wenb=0 until ack; then rf x7=dmem_rdata (0xDEADBEEF).
4. Zero-wait load (ack in the same cycle as req) → pipe_hold never asserts; mem_result=dmem_rdata that cycle.
5. exe_flush pulsed during a load wait → no EXE capture until hold drops, then exactly one bubble; the following instruction proceeds.
6. DEC rd=0 with dec_rd_wenb=1, and separately rst_n asserted while in WAIT → all wenb outputs stay 0 for the rd=0 case; after reset, dmem_req=0 and all outputs are at reset values.
